// File: rtl/hd44780_pkg.sv
// Shared states, command bytes and helpers for the HD44780 4-bit write engine.
package hd44780_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_N1,
        W1,
        INIT_N2,
        W2,
        INIT_N3,
        W3,
        INIT_N4,
        W4,
        INIT_CMDS,
        IDLE,
        SEND_HI,
        SEND_LO,
        EXEC_WAIT
    } engine_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD
    } tx_phase_t;

    localparam logic [7:0] FUNC_SET_4BIT_2LINE = 8'h28;
    localparam logic [7:0] DISP_ON             = 8'h0C;
    localparam logic [7:0] ENTRY_INC           = 8'h06;
    localparam logic [7:0] CLEAR               = 8'h01;
    localparam logic [7:0] HOME                = 8'h02;

    localparam logic [3:0] INIT_NIBBLE_8BIT = 4'h3;
    localparam logic [3:0] INIT_NIBBLE_4BIT = 4'h2;

    localparam int INIT_CMD_COUNT = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET_4BIT_2LINE;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY_INC;
            default: return CLEAR;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and Return Home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CLEAR) || (data[7:1] == HOME[7:1]));
    endfunction

endpackage

// File: rtl/hd44780_nibble_tx.sv
// Sends one nibble on the HD44780 4-bit bus: setup tick, E-high pulse, hold tick.
module hd44780_nibble_tx
    import hd44780_pkg::*;
#(
    parameter int E_PULSE_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       done
);

    localparam int PULSE_TICKS = (E_PULSE_TICKS < 1) ? 1 : E_PULSE_TICKS;
    localparam int PW          = $clog2(PULSE_TICKS + 1);

    tx_phase_t     phase_q, phase_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [3:0]    d_q;
    logic          rs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= TX_IDLE;
            cnt_q   <= '0;
            d_q     <= 4'h0;
            rs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (start) begin
                d_q  <= nibble;
                rs_q <= rs;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (phase_q)
            TX_SETUP: if (tick) phase_d = TX_PULSE;
            TX_PULSE: begin
                if (tick) begin
                    if (int'(cnt_q) + 1 >= PULSE_TICKS) phase_d = TX_HOLD;
                    else                                cnt_d   = cnt_q + 1'b1;
                end
            end
            TX_HOLD: begin
                if (tick) begin
                    phase_d = TX_IDLE;
                    done    = 1'b1;
                end
            end
            default: ;
        endcase
        // A new start may land on the finishing hold tick so byte halves run back to back.
        if (start) phase_d = TX_SETUP;
        if (phase_d != phase_q) cnt_d = '0;
    end

    assign lcd_e  = (phase_q == TX_PULSE);
    assign lcd_d  = d_q;
    assign lcd_rs = rs_q;

endmodule

// File: rtl/hd44780_write_engine.sv
// HD44780 4-bit write engine: power-on init, then byte writes over valid/ready, all timed in ticks.
module hd44780_write_engine
    import hd44780_pkg::*;
#(
    parameter int POWERUP_TICKS    = 15000,
    parameter int INIT_WAIT1_TICKS = 4100,
    parameter int INIT_WAIT2_TICKS = 100,
    parameter int E_PULSE_TICKS    = 1,
    parameter int CMD_TICKS        = 40,
    parameter int CLEAR_TICKS      = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_WAIT = max_int(max_int(max_int(POWERUP_TICKS, INIT_WAIT1_TICKS),
                                              max_int(INIT_WAIT2_TICKS, CMD_TICKS)),
                                      CLEAR_TICKS);
    localparam int CW = $clog2(MAX_WAIT + 1);

    engine_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic [2:0]    idx_q, idx_d;
    logic          init_done_q, init_done_d;
    logic          tx_start, tx_done, tx_rs;
    logic [3:0]    tx_nibble;
    logic          timed, expired;
    int            limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            idx_q       <= 3'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        timed       = 1'b1;
        limit       = CMD_TICKS;
        case (state_q)
            PWR_WAIT:  limit = POWERUP_TICKS;
            W1:        limit = INIT_WAIT1_TICKS;
            W2:        limit = INIT_WAIT2_TICKS;
            W3, W4:    limit = CMD_TICKS;
            EXEC_WAIT: limit = is_long_cmd(rs_q, byte_q) ? CLEAR_TICKS : CMD_TICKS;
            default:   timed = 1'b0;
        endcase
        expired = timed && tick && (int'(cnt_q) + 1 >= limit);
        if (timed && tick) cnt_d = cnt_q + 1'b1;

        case (state_q)
            PWR_WAIT: if (expired) state_d = INIT_N1;
            INIT_N1:  if (tx_done) state_d = W1;
            W1:       if (expired) state_d = INIT_N2;
            INIT_N2:  if (tx_done) state_d = W2;
            W2:       if (expired) state_d = INIT_N3;
            INIT_N3:  if (tx_done) state_d = W3;
            W3:       if (expired) state_d = INIT_N4;
            INIT_N4:  if (tx_done) state_d = W4;
            W4:       if (expired) state_d = INIT_CMDS;
            INIT_CMDS: begin
                byte_d  = init_cmd(idx_q[1:0]);
                rs_d    = 1'b0;
                idx_d   = idx_q + 3'd1;
                state_d = SEND_HI;
            end
            IDLE: begin
                if (in_valid && in_ready) begin
                    byte_d  = in_data;
                    rs_d    = in_rs;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: if (tx_done) state_d = SEND_LO;
            SEND_LO: if (tx_done) state_d = EXEC_WAIT;
            EXEC_WAIT: begin
                if (expired) begin
                    if (int'(idx_q) < INIT_CMD_COUNT) begin
                        state_d = INIT_CMDS;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            default: state_d = PWR_WAIT;
        endcase
        if (state_d != state_q) cnt_d = '0;

        // The transmitter latches on the edge that enters a nibble state, so it sees next-state values.
        tx_start  = (state_d != state_q) &&
                    (state_d inside {INIT_N1, INIT_N2, INIT_N3, INIT_N4, SEND_HI, SEND_LO});
        tx_nibble = INIT_NIBBLE_8BIT;
        tx_rs     = 1'b0;
        case (state_d)
            INIT_N4: tx_nibble = INIT_NIBBLE_4BIT;
            SEND_HI: begin
                tx_nibble = byte_d[7:4];
                tx_rs     = rs_d;
            end
            SEND_LO: begin
                tx_nibble = byte_d[3:0];
                tx_rs     = rs_d;
            end
            default: ;
        endcase
    end

    hd44780_nibble_tx #(
        .E_PULSE_TICKS(E_PULSE_TICKS)
    ) u_nibble_tx (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .start  (tx_start),
        .nibble (tx_nibble),
        .rs     (tx_rs),
        .lcd_e  (lcd_e),
        .lcd_d  (lcd_d),
        .lcd_rs (lcd_rs),
        .done   (tx_done)
    );

    assign in_ready  = (state_q == IDLE) && init_done_q;
    assign busy      = !in_ready;
    assign lcd_rw    = 1'b0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_hd44780_write_engine.sv
// Directed bench for hd44780_write_engine: init sequence, byte writes, stalls and mid-byte reset.
module tb_hd44780_write_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, lcd_rs, lcd_rw, lcd_e, init_done, busy;
    logic [3:0] lcd_d;

    int   compared = 0;
    int   mismatched = 0;
    int   ticks_issued = 0;
    int   div_cnt = 0;
    logic e_q = 1'b0;
    logic tick_en = 1'b1;

    logic [3:0] pulse_d[$];
    logic       pulse_rs[$];
    int         pulse_tick[$];

    typedef struct {
        logic [3:0] d;
        logic       rs;
        int         tick_at;
    } init_vec_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         ticks;
    } byte_vec_t;

    init_vec_t init_table[12];
    byte_vec_t byte_table[8];

    hd44780_write_engine #(
        .POWERUP_TICKS   (20),
        .INIT_WAIT1_TICKS(8),
        .INIT_WAIT2_TICKS(4),
        .E_PULSE_TICKS   (1),
        .CMD_TICKS       (3),
        .CLEAR_TICKS     (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rs    (in_rs),
        .in_data  (in_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_d    (lcd_d),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Tick every 4 clocks, driven on the falling edge; E pulses are logged with the tick count at rise.
    always @(negedge clk) begin
        if (!rst) begin
            ticks_issued = 0;
            div_cnt      = 0;
            tick         = 1'b0;
            e_q          = 1'b0;
            pulse_d.delete();
            pulse_rs.delete();
            pulse_tick.delete();
        end else begin
            if (lcd_e && !e_q) begin
                pulse_d.push_back(lcd_d);
                pulse_rs.push_back(lcd_rs);
                pulse_tick.push_back(ticks_issued);
            end
            if (!lcd_e && e_q && pulse_d.size() > 0) begin
                checkOutput("nibble_d_stable", lcd_d, pulse_d[pulse_d.size()-1]);
                checkOutput("nibble_rs_stable", lcd_rs, pulse_rs[pulse_rs.size()-1]);
            end
            e_q = lcd_e;
            if (tick_en) begin
                if (div_cnt == 3) begin
                    tick = 1'b1;
                    ticks_issued++;
                    div_cnt = 0;
                end else begin
                    tick = 1'b0;
                    div_cnt++;
                end
            end else begin
                tick = 1'b0;
            end
        end
    end

    task automatic checkInit();
        for (int i = 0; i < 1000 && !init_done; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("init_done_rise", init_done, 1);
        checkOutput("init_done_tick", ticks_issued, 93);
        checkOutput("ready_after_init", in_ready, 1);
        checkOutput("busy_after_init", busy, 0);
        checkOutput("init_pulse_count", pulse_d.size(), 12);
        for (int i = 0; i < 12 && i < pulse_d.size(); i++) begin
            checkOutput($sformatf("init_d[%0d]", i), pulse_d[i], init_table[i].d);
            checkOutput($sformatf("init_rs[%0d]", i), pulse_rs[i], init_table[i].rs);
            checkOutput($sformatf("init_tick[%0d]", i), pulse_tick[i], init_table[i].tick_at);
        end
    endtask

    // Offers a byte (valid held until the accept edge) and returns the tick count at acceptance.
    task automatic applyStimulus(input logic rs, input logic [7:0] data, output int acc_tick);
        in_rs    = rs;
        in_data  = data;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("ready_before_accept", in_ready, 1);
        pulse_d.delete();
        pulse_rs.delete();
        pulse_tick.delete();
        @(posedge clk); #1;
        acc_tick = ticks_issued;
        in_valid = 1'b0;
        in_rs    = ~rs;
        in_data  = ~data;
        checkOutput("ready_drop_after_accept", in_ready, 0);
    endtask

    task automatic checkByte(input string tag, input byte_vec_t v, input int acc_tick);
        for (int i = 0; i < 2000 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_ready_return"}, in_ready, 1);
        checkOutput({tag, "_accept_to_ready_ticks"}, ticks_issued - acc_tick, v.ticks);
        checkOutput({tag, "_pulse_count"}, pulse_d.size(), 2);
        if (pulse_d.size() == 2) begin
            checkOutput({tag, "_hi_nibble"}, pulse_d[0], v.hi);
            checkOutput({tag, "_lo_nibble"}, pulse_d[1], v.lo);
            checkOutput({tag, "_hi_rs"}, pulse_rs[0], v.rs);
            checkOutput({tag, "_lo_rs"}, pulse_rs[1], v.rs);
            checkOutput({tag, "_nibble_spacing"}, pulse_tick[1] - pulse_tick[0], 3);
        end
    endtask

    initial begin
        int        acc_tick;
        int        accepts;
        logic      was_ready;
        logic [7:0] sent, acc_byte;
        byte_vec_t v;

        init_table[0]  = '{4'h3, 1'b0, 21};
        init_table[1]  = '{4'h3, 1'b0, 32};
        init_table[2]  = '{4'h3, 1'b0, 39};
        init_table[3]  = '{4'h2, 1'b0, 45};
        init_table[4]  = '{4'h2, 1'b0, 51};
        init_table[5]  = '{4'h8, 1'b0, 54};
        init_table[6]  = '{4'h0, 1'b0, 60};
        init_table[7]  = '{4'hC, 1'b0, 63};
        init_table[8]  = '{4'h0, 1'b0, 69};
        init_table[9]  = '{4'h6, 1'b0, 72};
        init_table[10] = '{4'h0, 1'b0, 78};
        init_table[11] = '{4'h1, 1'b0, 81};

        byte_table[0] = '{1'b1, 8'h41, 4'h4, 4'h1, 9};
        byte_table[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 16};
        byte_table[2] = '{1'b0, 8'h80, 4'h8, 4'h0, 9};
        byte_table[3] = '{1'b0, 8'h02, 4'h0, 4'h2, 16};
        byte_table[4] = '{1'b0, 8'h03, 4'h0, 4'h3, 16};
        byte_table[5] = '{1'b0, 8'h04, 4'h0, 4'h4, 9};
        byte_table[6] = '{1'b0, 8'h00, 4'h0, 4'h0, 9};
        byte_table[7] = '{1'b1, 8'h01, 4'h0, 4'h1, 9};

        #2 rst = 1'b0;
        #10;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_lcd_rs", lcd_rs, 0);
        checkOutput("reset_lcd_rw", lcd_rw, 0);
        checkOutput("reset_lcd_e", lcd_e, 0);
        checkOutput("reset_lcd_d", lcd_d, 0);
        checkOutput("reset_init_done", init_done, 0);
        checkOutput("reset_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;

        checkInit();

        for (int i = 0; i < 8; i++) begin
            v = byte_table[i];
            applyStimulus(v.rs, v.data, acc_tick);
            checkByte($sformatf("byte%0d", i), v, acc_tick);
        end

        // Valid held with data changing every clock: exactly one accept, of the value on the accept edge.
        accepts  = 0;
        acc_byte = 8'h00;
        in_rs    = 1'b1;
        in_valid = 1'b1;
        pulse_d.delete();
        pulse_rs.delete();
        pulse_tick.delete();
        for (int i = 0; i < 300; i++) begin
            in_data   = 8'h37 + 8'(i * 13);
            was_ready = in_ready;
            sent      = in_data;
            @(posedge clk); #1;
            if (was_ready) begin
                accepts++;
                acc_byte = sent;
            end
            if (accepts > 0 && in_ready) break;
        end
        in_valid = 1'b0;
        checkOutput("held_valid_accepts", accepts, 1);
        checkOutput("held_valid_ready_return", in_ready, 1);
        checkOutput("held_valid_pulse_count", pulse_d.size(), 2);
        if (pulse_d.size() == 2) begin
            checkOutput("held_valid_hi", pulse_d[0], int'(acc_byte[7:4]));
            checkOutput("held_valid_lo", pulse_d[1], int'(acc_byte[3:0]));
        end

        // Tick stalled right after accept: outputs freeze in nibble setup, then resume cleanly.
        tick_en = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h5A, acc_tick);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stall_lcd_e", lcd_e, 0);
        checkOutput("stall_lcd_d", lcd_d, 5);
        checkOutput("stall_lcd_rs", lcd_rs, 1);
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_pulse_count", pulse_d.size(), 0);
        tick_en = 1'b1;
        v = '{1'b1, 8'h5A, 4'h5, 4'hA, 9};
        checkByte("stall_resume", v, acc_tick);

        // Reset during the second nibble's E-high phase, then the whole init must repeat.
        applyStimulus(1'b1, 8'h3C, acc_tick);
        for (int i = 0; i < 500 && !(pulse_d.size() == 2 && lcd_e); i++) begin
            @(posedge clk); #1;
        end
        checkOutput("midbyte_second_pulse_high", lcd_e, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midbyte_reset_lcd_e", lcd_e, 0);
        checkOutput("midbyte_reset_init_done", init_done, 0);
        checkOutput("midbyte_reset_in_ready", in_ready, 0);
        checkOutput("midbyte_reset_busy", busy, 1);
        checkOutput("midbyte_reset_lcd_d", lcd_d, 0);
        checkOutput("midbyte_reset_lcd_rs", lcd_rs, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        checkInit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
